// File: rtl/clock_timekeeper.sv
// ----------------------------------------------------------------------------
// clock_timekeeper
//   Wall-clock time of day kept as packed BCD hh:mm:ss, with a set mode.
//   The 1 Hz and 5 Hz square waves from the tick generator are synchronised
//   into clk_in.  Each rising edge becomes a one-cycle strobe (s1 / s5).
//   In RUN, s1 advances the time with a full carry ripple.
//   In SET, the hours and minutes buttons step their own field.  A button
//   press steps the field once.  Holding the button auto-repeats at 5 Hz
//   after HOLD_TICKS strobes.
//
//   Build option: define HOUR_12_EN for a 12-hour clock with a PM flag.
//   Hours then count 12,01..11.  With HOUR_12_EN left undefined, hours
//   count 00..23 and pm is tied to 0.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on the tick inputs (2..3)
//   HOLD_TICKS   5 Hz strobes a button is held before auto-repeat (1..15)
//
// Ports
//   clk_in       system clock
//   reset        asynchronous, active-high reset
//   tick_1Hz     1 Hz square wave; a rising edge means one second
//   tick_5Hz     5 Hz square wave; a rising edge is the repeat/blink strobe
//   set_mode     1 selects the SET state
//   inc_hours    hours button (debounced level)
//   inc_minutes  minutes button (debounced level)
//   hours_bcd    {tens,units} hours
//   minutes_bcd  {tens,units} minutes, 00..59
//   seconds_bcd  {tens,units} seconds, 00..59
//   pm           PM flag (12-hour build only)
//   sec_pulse    one-cycle pulse per accepted second advance
//   blink        display enable; follows the 5 Hz level while in SET
// ----------------------------------------------------------------------------
module clock_timekeeper #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_TICKS  = 5
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       tick_5Hz,
  input  logic       set_mode,
  input  logic       inc_hours,
  input  logic       inc_minutes,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       pm,
  output logic       sec_pulse,
  output logic       blink
);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_TICKS);

`ifdef HOUR_12_EN
  localparam logic [7:0] HOURS_RESET = 8'h12;
`else
  localparam logic [7:0] HOURS_RESET = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // Tick synchronisers and edge detectors
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync1_reg;
  logic [SYNC_STAGES-1:0] sync5_reg;
  logic                   edge1_reg;
  logic                   edge5_reg;
  logic                   s1;
  logic                   s5;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_in or posedge reset) begin
          if (reset) begin
            sync1_reg[gi] <= 1'b0;
            sync5_reg[gi] <= 1'b0;
          end else begin
            sync1_reg[gi] <= tick_1Hz;
            sync5_reg[gi] <= tick_5Hz;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk_in or posedge reset) begin
          if (reset) begin
            sync1_reg[gi] <= 1'b0;
            sync5_reg[gi] <= 1'b0;
          end else begin
            sync1_reg[gi] <= sync1_reg[gi-1];
            sync5_reg[gi] <= sync5_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      edge1_reg <= 1'b0;
      edge5_reg <= 1'b0;
    end else begin
      edge1_reg <= sync1_reg[SYNC_STAGES-1];
      edge5_reg <= sync5_reg[SYNC_STAGES-1];
    end
  end

  assign s1 = sync1_reg[SYNC_STAGES-1] & ~edge1_reg;
  assign s5 = sync5_reg[SYNC_STAGES-1] & ~edge5_reg;

  // --------------------------------------------------------------------------
  // BCD step helpers.  Each helper works digit by digit.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v == 8'h59)           return 8'h00;
    else if (v[3:0] == 4'h9)  return {v[7:4] + 4'h1, 4'h0};
    else                      return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] hours_inc(input logic [7:0] v);
`ifdef HOUR_12_EN
    if (v == 8'h12)           return 8'h01;
`else
    if (v == 8'h23)           return 8'h00;
`endif
    else if (v[3:0] == 4'h9)  return {v[7:4] + 4'h1, 4'h0};
    else                      return {v[7:4], v[3:0] + 4'h1};
  endfunction

  // --------------------------------------------------------------------------
  // State and time registers
  // --------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [7:0] hours_reg, hours_next;
  logic [7:0] minutes_reg, minutes_next;
  logic [7:0] seconds_reg, seconds_next;
  logic       sec_pulse_reg, sec_pulse_next;
  logic [3:0] hold_h_reg, hold_h_next;
  logic [3:0] hold_m_reg, hold_m_next;
  logic       btn_h_prev_reg;
  logic       btn_m_prev_reg;
`ifdef HOUR_12_EN
  logic       pm_reg, pm_next;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg      <= RUN;
      hours_reg      <= HOURS_RESET;
      minutes_reg    <= 8'h00;
      seconds_reg    <= 8'h00;
      sec_pulse_reg  <= 1'b0;
      hold_h_reg     <= 4'h0;
      hold_m_reg     <= 4'h0;
      btn_h_prev_reg <= 1'b0;
      btn_m_prev_reg <= 1'b0;
`ifdef HOUR_12_EN
      pm_reg         <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      hours_reg      <= hours_next;
      minutes_reg    <= minutes_next;
      seconds_reg    <= seconds_next;
      sec_pulse_reg  <= sec_pulse_next;
      hold_h_reg     <= hold_h_next;
      hold_m_reg     <= hold_m_next;
      btn_h_prev_reg <= inc_hours;
      btn_m_prev_reg <= inc_minutes;
`ifdef HOUR_12_EN
      pm_reg         <= pm_next;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic.  The RUN carry ripple and the SET buttons both reduce
  // to "step hours" / "step minutes" requests.  One increment path serves
  // both of them.
  // --------------------------------------------------------------------------
  logic changing;
  logic step_h;
  logic step_m;

  always_comb begin
    state_next     = set_mode ? SET : RUN;
    changing       = (state_next != state_reg);
    seconds_next   = seconds_reg;
    sec_pulse_next = 1'b0;
    hold_h_next    = hold_h_reg;
    hold_m_next    = hold_m_reg;
    step_h         = 1'b0;
    step_m         = 1'b0;

    case (state_reg)
      RUN: begin
        // A second arriving in the same cycle as a mode change is dropped.
        if (s1 && !changing) begin
          seconds_next   = bcd_inc60(seconds_reg);
          sec_pulse_next = 1'b1;
          if (seconds_reg == 8'h59) begin
            step_m = 1'b1;
            step_h = (minutes_reg == 8'h59);
          end
        end
      end
      SET: begin
        if (!changing) begin
          // Hours button.  A fresh press steps at once.  While the button is
          // held, strobes 1..HOLD_LIM are counted only; later strobes repeat.
          if (inc_hours && !btn_h_prev_reg) begin
            step_h      = 1'b1;
            hold_h_next = 4'h0;
          end else if (inc_hours) begin
            if (s5) begin
              step_h = (hold_h_reg >= HOLD_LIM);
              if (hold_h_reg != 4'hF) hold_h_next = hold_h_reg + 4'h1;
            end
          end else begin
            hold_h_next = 4'h0;
          end
          // The minutes button uses the same scheme.
          if (inc_minutes && !btn_m_prev_reg) begin
            step_m      = 1'b1;
            hold_m_next = 4'h0;
          end else if (inc_minutes) begin
            if (s5) begin
              step_m = (hold_m_reg >= HOLD_LIM);
              if (hold_m_reg != 4'hF) hold_m_next = hold_m_reg + 4'h1;
            end
          end else begin
            hold_m_next = 4'h0;
          end
        end
      end
      default: ;
    endcase

    if (changing && state_next == SET) begin
      seconds_next = 8'h00;
      hold_h_next  = 4'h0;
      hold_m_next  = 4'h0;
    end

    // Minutes wrap 59->00 by themselves.  The RUN carry into hours comes from
    // step_h above, so a SET wrap of minutes leaves hours alone.
    minutes_next = step_m ? bcd_inc60(minutes_reg) : minutes_reg;
    hours_next   = step_h ? hours_inc(hours_reg)   : hours_reg;
`ifdef HOUR_12_EN
    pm_next = (step_h && hours_reg == 8'h11) ? ~pm_reg : pm_reg;
`endif
  end

  assign hours_bcd   = hours_reg;
  assign minutes_bcd = minutes_reg;
  assign seconds_bcd = seconds_reg;
  assign sec_pulse   = sec_pulse_reg;
  assign blink       = (state_reg == SET) ? sync5_reg[SYNC_STAGES-1] : 1'b1;
`ifdef HOUR_12_EN
  assign pm = pm_reg;
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_timekeeper.sv
// ----------------------------------------------------------------------------
// tb_clock_timekeeper
//   Directed test of clock_timekeeper.
//   For every stimulated second, the tick task pushes the expected time and
//   pulse cycle into a queue.  An independent monitor pops one entry on each
//   sec_pulse and compares it.  SET-mode and reset results are checked
//   directly against a small integer time model.
// ----------------------------------------------------------------------------
module tb_clock_timekeeper;

  localparam int SYNC_STAGES = 2;
  localparam int HOLD_TICKS  = 5;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1Hz = 1'b0;
  logic       tick_5Hz = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_hours = 1'b0;
  logic       inc_minutes = 1'b0;
  logic [7:0] hours_bcd;
  logic [7:0] minutes_bcd;
  logic [7:0] seconds_bcd;
  logic       pm;
  logic       sec_pulse;
  logic       blink;

  clock_timekeeper #(.SYNC_STAGES(SYNC_STAGES), .HOLD_TICKS(HOLD_TICKS)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .tick_1Hz    (tick_1Hz),
    .tick_5Hz    (tick_5Hz),
    .set_mode    (set_mode),
    .inc_hours   (inc_hours),
    .inc_minutes (inc_minutes),
    .hours_bcd   (hours_bcd),
    .minutes_bcd (minutes_bcd),
    .seconds_bcd (seconds_bcd),
    .pm          (pm),
    .sec_pulse   (sec_pulse),
    .blink       (blink)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_count = 0;

  // Time model: hours 0..23, minutes and seconds 0..59.
  int mh = 0;
  int mm = 0;
  int ms = 0;

  typedef struct {
    int         cyc;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       p;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [7:0] hdisp(input int h);
`ifdef HOUR_12_EN
    int t;
    t = h % 12;
    if (t == 0) t = 12;
    return to_bcd(t);
`else
    return to_bcd(h);
`endif
  endfunction

  function automatic logic pdisp(input int h);
`ifdef HOUR_12_EN
    return (h >= 12);
`else
    return (h < 0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_time(input string tag);
    check({tag, "_hours"},   32'(hours_bcd),   32'(hdisp(mh)));
    check({tag, "_minutes"}, 32'(minutes_bcd), 32'(to_bcd(mm)));
    check({tag, "_seconds"}, 32'(seconds_bcd), 32'(to_bcd(ms)));
    check({tag, "_pm"},      32'(pm),          32'(pdisp(mh)));
    $display("check %s: %h:%h:%h pm=%0b", tag, hours_bcd, minutes_bcd, seconds_bcd, pm);
  endtask

  // Scoreboard monitor: every sec_pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (!reset && sec_pulse) begin
      pulse_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_sec_pulse", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle",   32'(cyc),         32'(e.cyc));
        check("pulse_hours",   32'(hours_bcd),   32'(e.h));
        check("pulse_minutes", 32'(minutes_bcd), 32'(e.m));
        check("pulse_seconds", 32'(seconds_bcd), 32'(e.s));
        check("pulse_pm",      32'(pm),          32'(e.p));
        $display("pulse cyc=%0d %h:%h:%h pm=%0b", cyc, hours_bcd, minutes_bcd, seconds_bcd, pm);
      end
    end
  end

  // One accepted second in RUN.
  task automatic tick_sec();
    exp_t e;
    @(posedge clk_in); #1;
    tick_1Hz = 1'b1;
    ms++;
    if (ms == 60) begin
      ms = 0;
      mm++;
      if (mm == 60) begin
        mm = 0;
        mh = (mh + 1) % 24;
      end
    end
    e.cyc = cyc + SYNC_STAGES + 1;
    e.h = hdisp(mh);
    e.m = to_bcd(mm);
    e.s = to_bcd(ms);
    e.p = pdisp(mh);
    exp_q.push_back(e);
    repeat (3) @(posedge clk_in);
    #1 tick_1Hz = 1'b0;
    repeat (4) @(posedge clk_in);
  endtask

  task automatic tick_5();
    @(posedge clk_in); #1 tick_5Hz = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 tick_5Hz = 1'b0;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic press(input bit hb, input bit mb);
    @(posedge clk_in); #1;
    inc_hours = hb;
    inc_minutes = mb;
    if (hb) mh = (mh + 1) % 24;
    if (mb) mm = (mm + 1) % 60;
    repeat (2) @(posedge clk_in);
    #1 inc_hours = 1'b0;
    inc_minutes = 1'b0;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic enter_set();
    @(posedge clk_in); #1 set_mode = 1'b1;
    ms = 0;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic leave_set();
    @(posedge clk_in); #1 set_mode = 1'b0;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in); reset = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    mh = 0; mm = 0; ms = 0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    repeat (3) @(negedge clk_in);
    // Reset values while reset is held.
    check_time("reset");
    check("reset_sec_pulse", 32'(sec_pulse), 32'd0);
    check("reset_blink",     32'(blink),     32'd1);
    reset = 1'b0;

    // 60 seconds -> 00:01:00, each pulse SYNC_STAGES+1 after its edge.
    pulse_count = 0;
    repeat (60) tick_sec();
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    check_time("after_60s");
    check("pulse_count_60", 32'(pulse_count), 32'd60);
    check("blink_run", 32'(blink), 32'd1);

    // Set 23:59 in SET, then 60 seconds roll over to 00:00:00.
    do_reset();
    enter_set();
    @(negedge clk_in);
    check("blink_set_low", 32'(blink), 32'd0);
    repeat (23) press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    @(negedge clk_in);
    check_time("set_2359");
    leave_set();
    repeat (60) tick_sec();
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    check_time("rollover");

    // Blink follows the synchronised 5 Hz level in SET.
    enter_set();
    @(posedge clk_in); #1 tick_5Hz = 1'b1;
    repeat (SYNC_STAGES - 1) @(posedge clk_in);
    @(negedge clk_in);
    check("blink_before_sync", 32'(blink), 32'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("blink_after_sync", 32'(blink), 32'd1);
    #1 tick_5Hz = 1'b0;
    repeat (4) @(posedge clk_in);

    // Hold minutes across 10 strobes: 1 on press + 5 repeats.
    @(posedge clk_in); #1 inc_minutes = 1'b1;
    repeat (10) tick_5();
    mm = 6;
    @(negedge clk_in);
    check_time("hold_repeat");
    @(posedge clk_in); #1 inc_minutes = 1'b0;
    tick_5();
    @(negedge clk_in);
    check_time("release_no_change");

    // Minutes 59 -> 00 in SET does not carry into hours.
    repeat (53) press(1'b0, 1'b1);
    @(negedge clk_in);
    check_time("set_min59");
    press(1'b0, 1'b1);
    @(negedge clk_in);
    check_time("min_wrap_no_carry");
    press(1'b1, 1'b1);
    @(negedge clk_in);
    check_time("both_buttons");

    // s1 coinciding with leaving SET is dropped.
    pc = pulse_count;
    @(posedge clk_in); #1 tick_1Hz = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk_in);
    #1 set_mode = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 tick_1Hz = 1'b0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    check_time("s1_at_set_fall");
    // s1 coinciding with entering SET is dropped (no pulse).
    @(posedge clk_in); #1 tick_1Hz = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk_in);
    #1 set_mode = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 tick_1Hz = 1'b0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    check_time("s1_at_set_rise");
    check("no_pulse_on_mode_change", 32'(pulse_count), 32'(pc));

    // Reach 12:34:56 and apply reset between clock edges.
    repeat (11) press(1'b1, 1'b0);
    repeat (33) press(1'b0, 1'b1);
    leave_set();
    repeat (56) tick_sec();
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    check_time("at_123456");
    #2 reset = 1'b1;
    mh = 0; mm = 0; ms = 0;
    #1;
    check_time("async_reset");
    check("async_reset_sec_pulse", 32'(sec_pulse), 32'd0);
    check("async_reset_blink",     32'(blink),     32'd1);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
